// File: rtl/nios2_pio_pkg.sv
// Shared definitions for the Nios II output PIO with pulse engine:
// register word addresses and the pulse timer state encoding.
package nios2_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  typedef enum logic [0:0] {
    PULSE_IDLE,
    PULSE_ACTIVE
  } pulse_state_e;

endpackage

// File: rtl/nios2_pio_out_pulse_if.sv
// Avalon-MM s1 slave bus bundle for the output PIO.
interface nios2_pio_out_pulse_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/nios2_pio_pulse_timer.sv
// One-shot pulse timer: latches a bit mask and holds it for len cycles.
// mask_next exposes the post-edge mask so the owner can register its output
// in step with busy.
module nios2_pio_pulse_timer
  import nios2_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 20,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] mask_in,
  output logic [DATA_WIDTH-1:0] mask_q,
  output logic [DATA_WIDTH-1:0] mask_next,
  output logic                  busy,
  output logic                  done,
  output logic                  drop
);

  pulse_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mask_d;

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    done    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      PULSE_IDLE: begin
        // Zero mask or zero length is a silent no-op.
        if (start && (mask_in != '0) && (len != '0)) begin
          state_d = PULSE_ACTIVE;
          cnt_d   = len;
          mask_d  = mask_in;
        end
      end
      PULSE_ACTIVE: begin
        drop = start;
        if (cnt_q == CNT_WIDTH'(1)) begin
          state_d = PULSE_IDLE;
          cnt_d   = '0;
          mask_d  = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = PULSE_IDLE;
    endcase
  end

  // State, counter and mask registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PULSE_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  assign mask_next = mask_d;
  assign busy      = (state_q == PULSE_ACTIVE);

endmodule

// File: rtl/nios2_pio_out_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a one-shot pulse engine
// that inverts masked output bits for PULSE_LEN cycles.
// Optional irq on pulse completion: define NIOS2_PIO_PULSE_IRQ_EN.
module nios2_pio_out_pulse
  import nios2_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 20,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  nios2_pio_out_pulse_if.slave  bus,
  output logic [DATA_WIDTH-1:0] out_port
`ifdef NIOS2_PIO_PULSE_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam logic [DATA_WIDTH-1:0] ResetData = RESET_VALUE[DATA_WIDTH-1:0];

  logic                  wr;
  logic [DATA_WIDTH-1:0] wdata_dw;
  logic [CNT_WIDTH-1:0]  wdata_cw;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  plen_q, plen_d;
  logic                  dropped_q, dropped_d;
  logic [DATA_WIDTH-1:0] out_d;
  logic                  status_wr;
  logic                  irq_bit;
  logic [DATA_WIDTH-1:0] mask_q, mask_next;
  logic                  busy, done, drop;
  logic                  unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign wdata_dw     = bus.writedata[DATA_WIDTH-1:0];
  assign wdata_cw     = bus.writedata[CNT_WIDTH-1:0];
  assign status_wr    = wr && (bus.address == ADDR_STATUS);
  assign unused_wdata = ^{bus.writedata, mask_q};

  nios2_pio_pulse_timer #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (wr && (bus.address == ADDR_PULSE)),
    .len       (plen_q),
    .mask_in   (wdata_dw),
    .mask_q    (mask_q),
    .mask_next (mask_next),
    .busy      (busy),
    .done      (done),
    .drop      (drop)
  );

  // Register-file write decode; output tracks post-edge data and mask.
  always_comb begin
    data_d    = data_q;
    plen_d    = plen_q;
    dropped_d = dropped_q;
    if (wr) begin
      case (bus.address)
        ADDR_DATA:      data_d = wdata_dw;
        ADDR_PULSE_LEN: plen_d = wdata_cw;
        ADDR_OUTSET:    data_d = data_q | wdata_dw;
        ADDR_OUTCLEAR:  data_d = data_q & ~wdata_dw;
        default:        ;
      endcase
    end
    if (status_wr) dropped_d = 1'b0;
    if (drop)      dropped_d = 1'b1;
    out_d = data_d ^ mask_next;
  end

  // Register file and registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= ResetData;
      plen_q    <= '0;
      dropped_q <= 1'b0;
      out_port  <= ResetData;
    end else begin
      data_q    <= data_d;
      plen_q    <= plen_d;
      dropped_q <= dropped_d;
      out_port  <= out_d;
    end
  end

`ifdef NIOS2_PIO_PULSE_IRQ_EN
  logic irq_q;

  // Completion interrupt; a same-edge set beats the STATUS-write clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (done) begin
      irq_q <= 1'b1;
    end else if (status_wr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif

  // Zero-wait-state read mux.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:      bus.readdata = 32'(data_q);
      ADDR_STATUS:    bus.readdata = {29'b0, irq_bit, dropped_q, busy};
      ADDR_PULSE_LEN: bus.readdata = 32'(plen_q);
      default:        bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios2_pio_out_pulse.sv
// Self-checking bench for nios2_pio_out_pulse (DATA_WIDTH 20, CNT_WIDTH 16,
// RESET_VALUE 0xF): directed vector table, corner sequences, random traffic
// against a cycle-indexed reference model.
module tb_nios2_pio_out_pulse;

  localparam logic [31:0] RV = 32'h0000F;
`ifdef NIOS2_PIO_PULSE_IRQ_EN
  localparam logic [31:0] IRQB = 32'h4;
`else
  localparam logic [31:0] IRQB = 32'h0;
`endif

  logic        clk;
  logic        reset;
  logic [19:0] out_port;
`ifdef NIOS2_PIO_PULSE_IRQ_EN
  logic        irq;
`endif

  nios2_pio_out_pulse_if bus ();

  nios2_pio_out_pulse #(
    .DATA_WIDTH  (20),
    .CNT_WIDTH   (16),
    .RESET_VALUE (RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
`ifdef NIOS2_PIO_PULSE_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the pulse is active in cycles m_cyc < m_pend, where
  // m_cyc counts clock edges.
  logic [19:0] m_data, m_pmask;
  logic [15:0] m_plen;
  longint      m_cyc = 0;
  longint      m_pend = 0;
  bit          m_drop, m_irq;

  function automatic bit m_active();
    return m_cyc < m_pend;
  endfunction

  function automatic logic [19:0] m_out();
    return m_data ^ (m_active() ? m_pmask : 20'h0);
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0:    return {12'h0, m_data};
      3'd1:    return {29'h0, (IRQB != 0) ? m_irq : 1'b0, m_drop, m_active()};
      3'd2:    return {16'h0, m_plen};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit wr, input logic [2:0] a,
                            input logic [31:0] wd);
    bit pre;
    pre = m_active();
    m_cyc++;
    if (r) begin
      m_data = RV[19:0]; m_plen = 0; m_pmask = 0; m_pend = 0;
      m_drop = 0; m_irq = 0;
    end else begin
      if (wr && a == 3'd1) begin m_drop = 0; m_irq = 0; end
      if (pre && m_cyc == m_pend) m_irq = 1;
      if (wr) begin
        case (a)
          3'd0: m_data = wd[19:0];
          3'd2: m_plen = wd[15:0];
          3'd3: begin
            if (pre) m_drop = 1;
            else if (wd[19:0] != 0 && m_plen != 0) begin
              m_pmask = wd[19:0];
              m_pend  = m_cyc + m_plen;
            end
          end
          3'd4: m_data = m_data | wd[19:0];
          3'd5: m_data = m_data & ~wd[19:0];
          default: ;
        endcase
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one bus cycle, step the model on the edge, settle 1ns after it.
  task automatic tick(input bit r, input bit cs, input bit wn, input logic [2:0] a,
                      input logic [31:0] wd);
    reset          = r;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    @(posedge clk);
    model_edge(r, cs && !wn, a, wd);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    tick(0, 1, 0, a, wd);
  endtask

  task automatic rd(input logic [2:0] a);
    tick(0, 1, 1, a, 32'h0);
  endtask

  task automatic chk_model(input string name);
    check({name, " out"}, 32'(out_port), 32'(m_out()));
    check({name, " rd"}, bus.readdata, m_rd(bus.address));
`ifdef NIOS2_PIO_PULSE_IRQ_EN
    check({name, " irq"}, 32'(irq), 32'(m_irq));
`endif
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [19:0] eo;
    logic [31:0] er;
  } vec_t;

  vec_t vt[$];

  initial begin
    reset = 1'b1; bus.chipselect = 0; bus.write_n = 1; bus.address = 0; bus.writedata = 0;

    vt.push_back('{1'b1, 1'b0, 3'd0, 32'hABCDE, 20'hABCDE, 32'hABCDE});
    vt.push_back('{1'b1, 1'b0, 3'd4, 32'h00100, 20'hABDDE, 32'h0});
    vt.push_back('{1'b1, 1'b1, 3'd0, 32'h0,     20'hABDDE, 32'hABDDE});
    vt.push_back('{1'b1, 1'b0, 3'd5, 32'h0000E, 20'hABDD0, 32'h0});
    vt.push_back('{1'b1, 1'b1, 3'd0, 32'h0,     20'hABDD0, 32'hABDD0});
    vt.push_back('{1'b1, 1'b0, 3'd0, 32'h0,     20'h0,     32'h0});
    vt.push_back('{1'b1, 1'b0, 3'd2, 32'h5,     20'h0,     32'h5});
    vt.push_back('{1'b1, 1'b0, 3'd3, 32'h1,     20'h1,     32'h0});
    for (int i = 0; i < 4; i++) vt.push_back('{1'b1, 1'b1, 3'd1, 32'h0, 20'h1, 32'h1});
    vt.push_back('{1'b1, 1'b1, 3'd1, 32'h0,     20'h0,     IRQB});
    vt.push_back('{1'b1, 1'b0, 3'd1, 32'h0,     20'h0,     32'h0});

    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);

    // Reset state across the whole map.
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check($sformatf("reset out a%0d", a), 32'(out_port), RV);
      check($sformatf("reset rd a%0d", a), bus.readdata, (a == 0) ? RV : 32'h0);
    end

    // Directed vector table: set/clear and a 5-cycle pulse.
    for (int i = 0; i < vt.size(); i++) begin
      tick(0, vt[i].cs, vt[i].wn, vt[i].a, vt[i].wd);
      check($sformatf("vec%0d out", i), 32'(out_port), 32'(vt[i].eo));
      check($sformatf("vec%0d rd", i), bus.readdata, vt[i].er);
      chk_model($sformatf("vec%0d model", i));
    end

    // PULSE during an active pulse is dropped and sticky.
    wr(3'd2, 32'd5);
    wr(3'd3, 32'h1);
    wr(3'd3, 32'h2);
    chk_model("drop start");
    for (int i = 0; i < 5; i++) begin rd(3'd1); chk_model("drop run"); end
    check("drop status", bus.readdata, 32'h2 | IRQB);
    wr(3'd1, 32'h0);
    rd(3'd1);
    check("drop cleared", bus.readdata, 32'h0);

    // Zero length or zero mask never starts a pulse.
    wr(3'd2, 32'd0);
    wr(3'd3, 32'h3);
    rd(3'd1);
    check("len0 status", bus.readdata, 32'h0);
    check("len0 out", 32'(out_port), 32'h0);
    wr(3'd2, 32'd5);
    wr(3'd3, 32'h0);
    rd(3'd1);
    check("mask0 status", bus.readdata, 32'h0);
    check("mask0 out", 32'(out_port), 32'h0);

    // Single-cycle pulse.
    wr(3'd2, 32'd1);
    wr(3'd3, 32'h80);
    check("len1 out", 32'(out_port), 32'h80);
    rd(3'd1);
    check("len1 after out", 32'(out_port), 32'h0);
    check("len1 after status", bus.readdata, IRQB);
    wr(3'd1, 32'h0);

    // Reset in the third cycle of a 10-cycle pulse, then a fresh pulse.
    wr(3'd0, 32'h5);
    wr(3'd2, 32'd10);
    wr(3'd3, 32'h30);
    rd(3'd1); chk_model("abort c2");
    tick(1, 1, 1, 3'd1, 32'h0);
    check("abort out", 32'(out_port), RV);
    rd(3'd1);
    check("abort status", bus.readdata, 32'h0);
    wr(3'd2, 32'd3);
    wr(3'd3, 32'h1);
    check("repulse out", 32'(out_port), RV ^ 32'h1);
    for (int i = 0; i < 4; i++) begin rd(3'd1); chk_model("repulse"); end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [2:0]  a;
      logic [31:0] wd;
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd2) wd = $urandom_range(0, 9);
      if (a == 3'd3 && $urandom_range(0, 3) == 0) wd = 0;
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), a, wd);
      chk_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
